// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping stage.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after TENS_MAX:ONES_MAX.
module bcd2_counter
    import stopwatch_pkg::*;
#(
    parameter int TENS_MAX = 5,
    parameter int ONES_MAX = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry
);

    logic at_limit;

    assign at_limit = (tens == bcd_t'(TENS_MAX)) && (ones == bcd_t'(ONES_MAX));
    // Combinational so the next stage can increment in the same cycle.
    assign carry    = inc && at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_limit) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == bcd_t'(DIGIT_MAX)) begin
                tens <= tens + bcd_t'(1);
                ones <= '0;
            end else begin
                ones <= ones + bcd_t'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS keeper: run/pause FSM, manual adjust and rollover pulse.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MINUTES = 99
) (
    input  logic clk,
    input  logic rst_n,
    input  logic one_hz_tick,
    input  logic two_hz_tick,
    input  logic pause_pulse,
    input  logic clr_pulse,
    input  logic adj,
    input  logic sel,
    output bcd_t min_tens,
    output bcd_t min_ones,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic running,
    output logic wrap_pulse
);

    state_t state, state_next;
    logic   run_tick, adj_tick;
    logic   sec_inc, min_inc, sec_carry, min_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PAUSED;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clr_pulse) begin
            state_next = state;
        end else if (adj) begin
            state_next = ADJUST;
        end else begin
            case (state)
                ADJUST:  state_next = PAUSED;
                PAUSED:  if (pause_pulse) state_next = RUN;
                RUN:     if (pause_pulse) state_next = PAUSED;
                default: state_next = PAUSED;
            endcase
        end
    end

    always_comb begin
        running = (state == RUN);
    end

    // A tick counts only in the state it belongs to, and never while clr or a
    // pending adjust entry outranks it.
    assign run_tick = !clr_pulse && !adj && (state == RUN) && one_hz_tick;
    assign adj_tick = !clr_pulse && adj && (state == ADJUST) && two_hz_tick;

    assign sec_inc = run_tick || (adj_tick && sel);
    assign min_inc = (run_tick && sec_carry) || (adj_tick && !sel);

    bcd2_counter #(
        .TENS_MAX(SEC_TENS_MAX),
        .ONES_MAX(DIGIT_MAX)
    ) u_sec (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_pulse),
        .inc  (sec_inc),
        .tens (sec_tens),
        .ones (sec_ones),
        .carry(sec_carry)
    );

    bcd2_counter #(
        .TENS_MAX(MAX_MINUTES / 10),
        .ONES_MAX(MAX_MINUTES % 10)
    ) u_min (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_pulse),
        .inc  (min_inc),
        .tens (min_tens),
        .ones (min_ones),
        .carry(min_carry)
    );

    // Registered so it lines up with the first cycle the digits read 00:00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wrap_pulse <= 1'b0;
        else        wrap_pulse <= run_tick && min_carry;
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench: directed plan plus random stimulus on MAX_MINUTES=99 and =9 instances,
// checked against an elapsed-seconds reference model.
module tb_stopwatch_counter;

    localparam int S_PAUSED = 0;
    localparam int S_RUN    = 1;
    localparam int S_ADJUST = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic one_hz_tick = 1'b0, two_hz_tick = 1'b0, pause_pulse = 1'b0;
    logic clr_pulse = 1'b0, adj = 1'b0, sel = 1'b0;

    logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
    logic       a_run, a_wrap, b_run, b_wrap;

    logic [15:0] obs_dig[2];
    logic        obs_run[2], obs_wrap[2];

    int  n_checks = 0;
    int  n_fails  = 0;
    int  maxm[2]  = '{99, 9};
    int  mm[2], ss[2], st[2];
    bit  wr[2];
    bit  a_lvl, s_lvl;

    always #5 clk = ~clk;

    stopwatch_counter #(.MAX_MINUTES(99)) dut_a (
        .clk(clk), .rst_n(rst_n), .one_hz_tick(one_hz_tick), .two_hz_tick(two_hz_tick),
        .pause_pulse(pause_pulse), .clr_pulse(clr_pulse), .adj(adj), .sel(sel),
        .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
        .running(a_run), .wrap_pulse(a_wrap)
    );

    stopwatch_counter #(.MAX_MINUTES(9)) dut_b (
        .clk(clk), .rst_n(rst_n), .one_hz_tick(one_hz_tick), .two_hz_tick(two_hz_tick),
        .pause_pulse(pause_pulse), .clr_pulse(clr_pulse), .adj(adj), .sel(sel),
        .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
        .running(b_run), .wrap_pulse(b_wrap)
    );

    assign obs_dig[0]  = {a_mt, a_mo, a_st, a_so};
    assign obs_dig[1]  = {b_mt, b_mo, b_st, b_so};
    assign obs_run[0]  = a_run;
    assign obs_run[1]  = b_run;
    assign obs_wrap[0] = a_wrap;
    assign obs_wrap[1] = b_wrap;

    function automatic logic [15:0] exp_dig(int k);
        return {4'(mm[k] / 10), 4'(mm[k] % 10), 4'(ss[k] / 10), 4'(ss[k] % 10)};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mm[k] = 0; ss[k] = 0; st[k] = S_PAUSED; wr[k] = 1'b0;
        end
    endfunction

    // Time kept as total seconds modulo (MAX+1) minutes; adjust edits one field modulo its range.
    function automatic void model_step(int k, bit p, bit c, bit a, bit s, bit o, bit t);
        int total;
        wr[k] = 1'b0;
        if (c) begin
            mm[k] = 0; ss[k] = 0;
        end else if (a) begin
            if (st[k] == S_ADJUST && t) begin
                if (s) ss[k] = (ss[k] + 1) % 60;
                else   mm[k] = (mm[k] + 1) % (maxm[k] + 1);
            end
            st[k] = S_ADJUST;
        end else begin
            if (st[k] == S_RUN && o) begin
                total = (mm[k] * 60 + ss[k] + 1) % ((maxm[k] + 1) * 60);
                wr[k] = (total == 0);
                mm[k] = total / 60;
                ss[k] = total % 60;
            end
            if (st[k] == S_ADJUST)                  st[k] = S_PAUSED;
            else if (st[k] == S_PAUSED && p)        st[k] = S_RUN;
            else if (st[k] == S_RUN && p)           st[k] = S_PAUSED;
        end
    endfunction

    task automatic check(string tag);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            assert (obs_dig[k] === exp_dig(k)) else begin
                n_fails++;
                $error("FAIL %s[%0d] digits: observed %h required %h", tag, k, obs_dig[k], exp_dig(k));
            end
            n_checks++;
            assert (obs_run[k] === (st[k] == S_RUN)) else begin
                n_fails++;
                $error("FAIL %s[%0d] running: observed %b required %b", tag, k, obs_run[k], st[k] == S_RUN);
            end
            n_checks++;
            assert (obs_wrap[k] === wr[k]) else begin
                n_fails++;
                $error("FAIL %s[%0d] wrap_pulse: observed %b required %b", tag, k, obs_wrap[k], wr[k]);
            end
        end
    endtask

    task automatic step(bit p, bit c, bit a, bit s, bit o, bit t, string tag);
        pause_pulse = p; clr_pulse = c; adj = a; sel = s; one_hz_tick = o; two_hz_tick = t;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, p, c, a, s, o, t);
        #1;
        check(tag);
        pause_pulse = 0; clr_pulse = 0; one_hz_tick = 0; two_hz_tick = 0;
    endtask

    task automatic run_ticks(int n, string tag);
        repeat (n) step(0, 0, 0, 0, 1, 0, tag);
    endtask

    task automatic adj_ticks(bit s, int n, string tag);
        repeat (n) step(0, 0, 1, s, 0, 1, tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset");
        @(negedge clk) rst_n = 1'b1;

        // Start and count 61 seconds back to back.
        step(1, 0, 0, 0, 0, 0, "start");
        run_ticks(61, "count61");

        // Preload 99:58 (09:58 on the small instance) then roll over.
        step(1, 0, 0, 0, 0, 0, "pause");
        step(0, 1, 0, 0, 0, 0, "clr_paused");
        adj_ticks(0, 99, "preload_min");
        adj_ticks(1, 58, "preload_sec");
        step(0, 0, 0, 0, 0, 0, "exit_adj");
        step(0, 0, 0, 0, 1, 0, "paused_tick_ignored");
        step(1, 0, 0, 0, 0, 0, "run_again");
        run_ticks(2, "rollover");
        step(0, 0, 0, 0, 0, 0, "wrap_one_cycle");

        // Adjust wraps: seconds without carry, minutes at limit.
        step(0, 0, 1, 1, 1, 0, "enter_adj_drops_tick");
        adj_ticks(1, 58, "adj_sec_to58");
        adj_ticks(1, 3, "adj_sec_wrap");
        step(1, 0, 1, 1, 1, 0, "adj_ignores_pause_1hz");
        adj_ticks(0, 99, "adj_min_to_max");
        adj_ticks(0, 1, "adj_min_wrap");

        // Pause and tick together in RUN: tick counted, then paused.
        step(0, 0, 0, 0, 0, 0, "exit_adj2");
        step(0, 1, 0, 0, 0, 0, "clr2");
        step(1, 0, 0, 0, 0, 0, "run3");
        run_ticks(10, "to_0010");
        step(1, 0, 0, 0, 1, 0, "pause_and_tick_run");
        run_ticks(5, "paused_hold");
        step(1, 0, 0, 0, 1, 0, "pause_and_tick_paused");

        // Clear with tick in RUN at 12:34.
        step(1, 0, 0, 0, 0, 0, "pause4");
        step(0, 1, 0, 0, 0, 0, "clr4");
        adj_ticks(0, 12, "set_min12");
        adj_ticks(1, 34, "set_sec34");
        step(0, 0, 0, 0, 0, 0, "exit_adj4");
        step(1, 0, 0, 0, 0, 0, "run4");
        step(0, 1, 0, 0, 1, 0, "clr_beats_tick");
        run_ticks(5, "count_after_clr");

        // Asynchronous reset mid-count.
        rst_n = 1'b0;
        #1 model_reset();
        check("async_reset");
        @(negedge clk) rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 0, "post_reset_paused");
        step(1, 0, 0, 0, 0, 0, "first_pause_after_reset");
        run_ticks(3, "post_reset_count");

        // Random traffic.
        a_lvl = 1'b0; s_lvl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 31) == 0) a_lvl = ~a_lvl;
            if ($urandom_range(0, 7) == 0)  s_lvl = ~s_lvl;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0, a_lvl, s_lvl,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
